// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types, constants and helpers for the multiply/divide unit
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Low 64 bits of the product of the sign- or zero-extended operands.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_core
// Description : Unsigned restoring divider, one quotient bit per clock
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        ready
);

    logic [63:0] r_rq;
    logic [31:0] r_d;
    logic [5:0]  r_cnt;

    function automatic logic [63:0] step(input logic [63:0] rq, input logic [31:0] d);
        logic [32:0] trial;
        trial = rq[63:31] - {1'b0, d};
        if (!trial[32]) begin
            return {trial[31:0], rq[30:0], 1'b1};
        end
        return {rq[62:0], 1'b0};
    endfunction

    // The load edge already performs the first iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rq  <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_d   <= divisor;
            r_rq  <= step({32'b0, dividend}, divisor);
            r_cnt <= 6'(DIV_ITER - 1);
        end else if (r_cnt != 6'd0) begin
            r_rq  <= step(r_rq, r_d);
            r_cnt <= r_cnt - 6'd1;
        end
    end

    // Asserted while the final iteration is being clocked in.
    assign ready     = (r_cnt == 6'd1);
    assign quotient  = r_rq[31:0];
    assign remainder = r_rq[63:32];

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Execute-stage multiply/divide unit owning the HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  mdu_op_t     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_mul_init = 3'(MUL_LAT - 1);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic [2:0]  r_mul_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_sgn;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [31:0] r_dividend;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_sgn_op;
    logic        w_fin_mul;
    logic        w_fin_div;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic        w_msgn;
    logic [63:0] w_prod;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_ready;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign busy     = (r_state != IDLE);
    assign w_accept = start && !busy && !flush;
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_sgn_op = (op == OP_MULT) || (op == OP_DIV);

    // One multiplier: fed straight from the issue operands when MUL_LAT is 1.
    assign w_ma   = (r_state == MUL) ? r_mul_a   : src_a;
    assign w_mb   = (r_state == MUL) ? r_mul_b   : src_b;
    assign w_msgn = (r_state == MUL) ? r_mul_sgn : w_sgn_op;
    assign w_prod = mul64(w_ma, w_mb, w_msgn);

    assign w_div_a = (w_sgn_op && src_a[31]) ? -src_a : src_a;
    assign w_div_b = (w_sgn_op && src_b[31]) ? -src_b : src_b;

    mdu_div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (w_accept && w_is_div),
        .dividend  (w_div_a),
        .divisor   (w_div_b),
        .quotient  (w_quo),
        .remainder (w_rem),
        .ready     (w_div_ready)
    );

    assign w_quo_fix = r_div_zero ? DIV0_Q     : (r_neg_q ? -w_quo : w_quo);
    assign w_rem_fix = r_div_zero ? r_dividend : (r_neg_r ? -w_rem : w_rem);

    always_comb begin
        w_state_nxt = r_state;
        w_fin_mul   = 1'b0;
        w_fin_div   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) begin
                    if (MUL_LAT == 1) w_fin_mul = 1'b1;
                    else              w_state_nxt = MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_nxt = DIV;
                end
            end
            MUL: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (r_mul_cnt == 3'd1) begin
                    w_state_nxt = IDLE;
                    w_fin_mul   = 1'b1;
                end
            end
            DIV: begin
                if (flush)            w_state_nxt = IDLE;
                else if (w_div_ready) w_state_nxt = FIX;
            end
            FIX: begin
                w_state_nxt = IDLE;
                w_fin_div   = !flush;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_mul_cnt  <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_sgn  <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_fin_mul | w_fin_div;

            if (w_accept && w_is_mul) begin
                r_mul_a   <= src_a;
                r_mul_b   <= src_b;
                r_mul_sgn <= w_sgn_op;
                r_mul_cnt <= c_mul_init;
            end else if (r_state == MUL) begin
                r_mul_cnt <= r_mul_cnt - 3'd1;
            end

            if (w_accept && w_is_div) begin
                r_neg_q    <= w_sgn_op && (src_a[31] ^ src_b[31]);
                r_neg_r    <= w_sgn_op && src_a[31];
                r_div_zero <= (src_b == 32'd0);
                r_dividend <= src_a;
            end

            if (w_fin_mul) begin
                {r_hi, r_lo} <= w_prod;
            end else if (w_fin_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else if (w_accept && op == OP_MTHI) begin
                r_hi <= src_a;
            end else if (w_accept && op == OP_MTLO) begin
                r_lo <= src_a;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu against an arithmetic HI/LO model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    localparam int MUL_LAT  = 3;
    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    mdu_op_t     op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    mdu #(
        .MUL_LAT  (MUL_LAT),
        .DIV_ITER (DIV_ITER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted instruction on HI/LO.
    function automatic void model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        int              qa;
        int              qb;
        case (o)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                {m_hi, m_lo} = 64'(sa * sb);
            end
            OP_MULTU: begin
                ua = {32'b0, a};
                ub = {32'b0, b};
                {m_hi, m_lo} = ua * ub;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    m_lo = 32'(qa / qb);
                    m_hi = 32'(qa % qb);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic do_short(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick;
        start = 1'b0;
        check("short hi",   hi, m_hi);
        check("short lo",   lo, m_lo);
        check("short busy", {31'b0, busy}, 32'd0);
        check("short done", {31'b0, done}, 32'd0);
    endtask

    // Issue a long op; optionally keep hammering start with writes while busy.
    task automatic do_long(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                           input bit hammer);
        int          lat;
        logic [31:0] oh;
        logic [31:0] ol;
        bit          hold_ok;
        lat     = (o == OP_MULT || o == OP_MULTU) ? MUL_LAT : DIV_ITER + 1;
        oh      = m_hi;
        ol      = m_lo;
        hold_ok = 1'b1;
        model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick;
        start = hammer;
        if (hammer) begin
            op    = ($urandom_range(0, 1) == 1) ? OP_MTHI : OP_MULT;
            src_a = $urandom;
            src_b = $urandom;
        end
        for (int k = 1; k < lat; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hi !== oh || lo !== ol) hold_ok = 1'b0;
            tick;
        end
        start = 1'b0;
        check($sformatf("%s busy-window", o.name()), {31'b0, hold_ok}, 32'd1);
        check($sformatf("%s hi", o.name()), hi, m_hi);
        check($sformatf("%s lo", o.name()), lo, m_lo);
        check($sformatf("%s done", o.name()), {31'b0, done}, 32'd1);
        check($sformatf("%s busy-end", o.name()), {31'b0, busy}, 32'd0);
        tick;
        check($sformatf("%s done-pulse", o.name()), {31'b0, done}, 32'd0);
    endtask

    initial begin
        mdu_op_t     o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] oh;
        logic [31:0] ol;
        bit          seen_done;
        bit          stay_busy;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = OP_MULT; src_a = '0; src_b = '0;
        tick; tick;
        reset = 1'b0;
        check("reset hi",   hi, 32'd0);
        check("reset lo",   lo, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);

        do_short(OP_MTHI, 32'h1234_5678, 32'd0);
        do_short(OP_MTLO, 32'h9ABC_DEF0, 32'd0);

        do_long(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        do_long(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_long(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        do_long(OP_DIVU,  32'd100,       32'd7, 1'b0);
        do_long(OP_DIVU,  32'd5,         32'd0, 1'b0);
        do_long(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_long(OP_DIV,   32'd12345,     32'hFFFF_FFF0, 1'b1);

        // Flush a divide mid-flight, then a multiply right behind it.
        oh = m_hi; ol = m_lo; seen_done = 1'b0; stay_busy = 1'b1;
        op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done) seen_done = 1'b1;
            if (busy !== 1'b1) stay_busy = 1'b0;
            tick;
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush busy-before", {31'b0, stay_busy}, 32'd1);
        check("flush busy",   {31'b0, busy}, 32'd0);
        check("flush done",   {31'b0, done | seen_done}, 32'd0);
        check("flush hi",     hi, oh);
        check("flush lo",     lo, ol);
        do_long(OP_MULT, 32'd6, 32'd7, 1'b0);

        // Flush and start together: the start is dropped.
        op = OP_MULT; src_a = $urandom; src_b = $urandom; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {31'b0, busy}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            if (done) seen_done = 1'b1;
            tick;
        end
        check("flush+start done", {31'b0, seen_done}, 32'd0);
        check("flush+start hi", hi, m_hi);
        check("flush+start lo", lo, m_lo);
        op = OP_MTHI; src_a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        check("flush+mthi hi", hi, m_hi);

        // Flush in the completion cycle leaves the result in place.
        a = $urandom; b = $urandom;
        model(OP_MULTU, a, b);
        op = OP_MULTU; src_a = a; src_b = b; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < MUL_LAT; k++) tick;
        flush = 1'b1;
        check("cmpl-flush done", {31'b0, done}, 32'd1);
        tick;
        flush = 1'b0;
        check("cmpl-flush hi", hi, m_hi);
        check("cmpl-flush lo", lo, m_lo);

        for (int i = 0; i < 24; i++) begin
            o = mdu_op_t'(3'($urandom_range(0, 7)));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: a = $urandom_range(0, 1000);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})
                do_long(o, a, b, bit'($urandom_range(0, 1)));
            else
                do_short(o, a, b);
        end

        // Start while busy is ignored; reset mid-divide discards everything.
        op = OP_DIV; src_a = $urandom; src_b = 32'd9; start = 1'b1;
        tick;
        op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
        tick; tick; tick;
        check("ignore busy", {31'b0, busy}, 32'd1);
        check("ignore hi", hi, m_hi);
        check("ignore lo", lo, m_lo);
        tick;
        reset = 1'b1; start = 1'b0;
        tick;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midreset hi",   hi, 32'd0);
        check("midreset lo",   lo, 32'd0);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < MUL_LAT + 1; k++) begin
            if (done || busy) seen_done = 1'b1;
            tick;
        end
        check("midreset quiet", {31'b0, seen_done}, 32'd0);
        do_long(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Execute-stage multiply/divide unit. It runs beside the ALU and takes the same issue-slot operands (SrcA/SrcB).
- Holds the architectural HI/LO registers. Executes MULT/MULTU as fixed-latency operations and DIV/DIVU as multi-cycle iterative operations. Also executes MTHI/MTLO.
- Exposes busy so issue logic can stall any later HI/LO access. Exposes done so MFHI/MFLO forwarding knows when HI/LO are fresh.

Parameters:
- MUL_LAT, 3, cycles from accept to HI/LO update for MULT/MULTU; legal range 1..8.
- DIV_ITER, 32, restoring-division iterations; fixed at 32, present for bench shortening only.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  operation request, valid this cycle
- op  in  3  mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are no-op
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush; aborts the in-flight op
- busy  out  1  long op in flight; new start is ignored
- done  out  1  one-cycle pulse, HI/LO just updated by a long op
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: start&&!busy&&!flush in cycle N.
- MTHI/MTLO: hi (or lo) = src_a, visible in cycle N+1. No busy, no done. FSM stays IDLE.
- MULT/MULTU:
  - Operands are captured at the accept edge and the FSM enters MUL; a counter loads MUL_LAT-1.
  - {hi,lo} = 64-bit signed (MULT) or unsigned (MULTU) product, visible in cycle N+MUL_LAT, with done=1 in that cycle.
  - busy is high in cycles N+1..N+MUL_LAT-1. If MUL_LAT=1, busy never rises and the FSM returns to IDLE at once.
- DIV/DIVU:
  - At accept, capture |src_a| and |src_b| (signed) or raw values (unsigned), plus both sign bits, then enter DIV.
  - DIV: one restoring iteration per cycle for DIV_ITER cycles.
  - FIX: one cycle. Apply signs: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Result: lo=quotient, hi=remainder, visible in cycle N+DIV_ITER+1, with done=1 then. busy is high in cycles N+1..N+DIV_ITER.
- Divide boundary cases (constant latency is kept in every case):
  - Divisor zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=src_a. Detected at accept.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0. No trap.
- Start while busy: ignored and no state change. Issue logic must stall; the unit does not queue.
- Flush: while busy, the FSM goes to IDLE in the next cycle. HI/LO keep their old values and no done is produced.
- Flush in the completion cycle: the update already made stands, since it belongs to an older instruction.
- Flush and start in the same cycle: flush wins and the start is dropped.
- MTHI/MTLO arriving in the cycle a long op completes cannot occur (busy blocks it). Any write while busy is ignored.
- done is registered and lasts exactly one cycle. hi/lo are driven only by flops.

Decomposition:
- mdu_pkg holds:
  - typedef enum logic [2:0] mdu_op_t
  - typedef enum mdu_state_t {IDLE, MUL, DIV, FIX}
  - constants DIV0_Q=32'hFFFFFFFF and INT_MIN=32'h80000000
- Sub-module mdu_div_core: restoring-division datapath with a 64-bit remainder/quotient shift register and a 6-bit iteration counter.
  - Interface: load, magnitudes in; quotient and remainder out; ready.
  - Sign capture/fix, the multiplier and HI/LO stay in mdu.

Test Plan:
- Reset then MTHI 32'h12345678 and MTLO 32'h9ABCDEF0 on back-to-back cycles -> hi/lo hold those values on the next cycles; busy stays 0.
- MULT src_a=32'hFFFFFFFE (-2), src_b=3 -> in cycle N+3: hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done=1 for one cycle. MULTU on the same operands -> hi=2, lo=32'hFFFFFFFA.
- DIV -7 / 2 -> in cycle N+33: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. busy is high in cycles N+1..N+32.
- DIVU 5/0 -> lo=32'hFFFFFFFF, hi=5. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0. Latency is 33 in both cases.
- Start DIV 100/7, then flush at cycle N+10 -> busy=0 from N+11, hi/lo unchanged, no done. A MULT 6*7 accepted at N+11 -> lo=42 at N+14.
- Start DIV, drive start=1 with MULT during busy, and assert reset at N+5 -> the MULT is ignored; after reset hi=lo=0, busy=0, done=0.
